dmem_pipelined_access_unit: RTL
===============================

// Module: dmem_pipelined_access_unit
// PURPOSE
//  Pipelined replacement for the single-outstanding dmem read/write unit. It sits between the
//  load-store unit and data memory and keeps up to MAX_OUT requests in flight, responses in order.
//  Supports byte/half/word sizes with byte enables and load sign/zero extension.
//  Discards squashed speculative ops at pop; a flush kills in-flight loads before broadcast.
// PARAMETERS
//  DATA_W   32  dmem data width; 32 or 64 only
//  ADDR_W   32  dmem address width
//  MAX_OUT  4   max outstanding dmem transactions (>=1); sizes pending FIFO and credit counter
// PORTS
//  clk_i              in   1         clock, rising edge
//  reset_i            in   1         asynchronous, active-high reset
//  lsu_empty_i        in   1         LSU queue empty
//  lsu_instr_ready_i  in   1         LSU head operands resolved
//  lsu_load_i         in   1         head is load (1) / store (0)
//  lsu_size_i         in   2         0=byte 1=half 2=word 3=dword (DATA_W=64 only)
//  lsu_signed_i       in   1         load sign-extends
//  lsu_eff_addr_i     in   ADDR_W    head effective address
//  lsu_st_data_i      in   DATA_W    store data, LSB-aligned
//  lsu_ld_tag_i       in   rs_tag_t  load destination tag
//  lsu_specultative_i in   1         head is speculative
//  lsu_corr_pred_i    in   1         prediction resolved correct
//  flush_i            in   1         mispredict flush: kill all in-flight loads
//  lsu_read_o         out  1         pop LSU head this cycle
//  cdb_load_o         out  cdb_t     load result broadcast (tag NO_VAL = idle)
//  misalign_o         out  1         1-cycle pulse: popped access was misaligned, dropped
//  dmem_req_o         out  1         request valid; held until dmem_gnt_i
//  dmem_we_o          out  1         1 = write
//  dmem_be_o          out  DATA_W/8  byte enables
//  dmem_addr_o        out  ADDR_W    word-aligned address (offset bits zero)
//  dmem_wdata_o       out  DATA_W    store data shifted into lane position
//  dmem_gnt_i         in   1         request accepted this cycle
//  dmem_rvalid_i      in   1         in-order response (loads and stores both respond)
//  dmem_rdata_i       in   DATA_W    read data, full word
// BEHAVIOUR
//  Reset: all outputs 0, cdb_load_o.tag=NO_VAL, FSM=IDLE, pending FIFO empty, credit count 0.
//  Credits: cnt = requests granted-not-responded + (FSM==REQ). +1 on pop-to-issue, -1 on rvalid;
//   same-cycle pop and rvalid leave cnt unchanged. Pop allowed only when cnt<MAX_OUT.
//  Pop: lsu_read_o=1 when ~lsu_empty_i & lsu_instr_ready_i & cnt<MAX_OUT & (FSM==IDLE | gnt).
//   Squashed (spec & ~corr_pred): popped, no request, no credit. Misaligned (addr % size!=0):
//   popped, misalign_o pulses next cycle, no request.
//  FSM IDLE->REQ on valid pop; next cycle dmem_req_o=1 with registered addr/be/wdata/we.
//   REQ & gnt & new pop -> REQ (back-to-back, 1 req/cycle); REQ & gnt & no pop -> IDLE;
//   REQ & ~gnt -> REQ, outputs stable.
//  On gnt push {is_load, tag, size, signed, byte offset, kill=0} into pending FIFO.
//  On rvalid pop FIFO; if load & ~kill: extract lane at offset, sign/zero-extend to 32 bits,
//   drive cdb_load_o {tag,val} registered, 1 cycle after rvalid. Stores/killed loads: NO_VAL.
//  flush_i: sets kill on every FIFO entry and on the REQ-held load (request still completes,
//   bus is never retracted); LSU pop is blocked in the flush cycle.
//  rvalid with empty FIFO is a protocol error: ignored (assertion in bench).
//  Reset mid-operation clears FIFO/FSM immediately; dmem shares reset_i.
//  Pop-to-CDB latency with gnt same cycle and 1-cycle memory: 3 cycles.
// TESTING
//  Word load addr 0x100 tag 5, gnt immediate, rvalid next cycle rdata 0xDEADBEEF -> cdb tag5 val 0xDEADBEEF.
//  Signed byte load addr 0x103, rdata 0x80FFFFFF -> be=4'b1000, cdb val 0xFFFFFF80; unsigned -> 0x00000080.
//  Half store addr 0x102 data 0x1234 -> dmem_be_o=4'b1100, wdata=0x12340000, no CDB broadcast.
//  MAX_OUT=4, 6 loads, gnt=1, rvalid withheld -> exactly 4 granted, lsu_read_o low until first rvalid.
//  3 loads in flight, flush_i pulse, then load tag 9 -> 3 responses give NO_VAL, tag 9 broadcasts.
//  Squashed spec head and half load at 0x101 -> both popped, no dmem_req_o, misalign_o pulses once.

Source files
------------

// File: rtl/dmem_pipelined_access_unit_if.sv
// Shared tag/CDB types and the dmem request/response bus between the access unit and data memory.
package dmem_pipelined_access_unit_pkg;
  localparam int unsigned TAG_W = 4;
  typedef logic [TAG_W-1:0] rs_tag_t;
  // Tag value 0 marks an idle CDB slot.
  localparam rs_tag_t NO_VAL = '0;
  typedef struct packed {
    rs_tag_t     tag;
    logic [31:0] val;
  } cdb_t;
endpackage

interface dmem_pipelined_access_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // Access unit side
  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  // Memory side
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_pipelined_access_unit.sv
// Pipelined LSU-to-dmem access unit: up to MAX_OUT in-order requests in flight,
// byte/half/word(/dword) lanes, load extension, squash and flush handling.
module dmem_pipelined_access_unit
  import dmem_pipelined_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                lsu_empty_i,
  input  logic                lsu_instr_ready_i,
  input  logic                lsu_load_i,
  input  logic [1:0]          lsu_size_i,
  input  logic                lsu_signed_i,
  input  logic [ADDR_W-1:0]   lsu_eff_addr_i,
  input  logic [DATA_W-1:0]   lsu_st_data_i,
  input  rs_tag_t             lsu_ld_tag_i,
  input  logic                lsu_specultative_i,
  input  logic                lsu_corr_pred_i,
  input  logic                flush_i,
  output logic                lsu_read_o,
  output cdb_t                cdb_load_o,
  output logic                misalign_o,
  dmem_pipelined_access_unit_if.master dmem
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic {S_IDLE, S_REQ} state_e;

  // Book-keeping for one granted request awaiting its response.
  typedef struct packed {
    logic             is_load;
    rs_tag_t          tag;
    logic [1:0]       size;
    logic             sgn;
    logic [OFF_W-1:0] off;
    logic             kill;
  } pend_t;

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  pend_t             r_fifo [MAX_OUT];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_fcnt;

  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req_load;
  rs_tag_t           r_req_tag;
  logic [1:0]        r_req_size;
  logic              r_req_sgn;
  logic [OFF_W-1:0]  r_req_off;
  logic              r_req_kill;

  cdb_t              r_cdb;
  logic              r_misalign;

  logic              w_squash, w_misalign, w_credit_ok, w_pop, w_issue, w_push, w_rsp;
  logic [OFF_W-1:0]  w_off;
  logic [BE_W-1:0]   w_be_mask;
  pend_t             w_head;
  logic [DATA_W-1:0] w_lane;
  logic [31:0]       w_ld_val;
  logic              w_rsp_kill;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_off       = lsu_eff_addr_i[OFF_W-1:0];
  assign w_squash    = lsu_specultative_i & ~lsu_corr_pred_i;
  assign w_credit_ok = (r_cnt < CNT_W'(MAX_OUT));
  // Head may leave the LSU when idle, or when the held request is being granted this cycle.
  assign w_pop       = ~lsu_empty_i & lsu_instr_ready_i & w_credit_ok & ~flush_i &
                       ((r_state == S_IDLE) | ((r_state == S_REQ) & dmem.gnt));
  assign w_issue     = w_pop & ~w_squash & ~w_misalign;
  assign w_push      = (r_state == S_REQ) & dmem.gnt;
  // A response with nothing pending is a protocol error and is ignored.
  assign w_rsp       = dmem.rvalid & (r_fcnt != '0);

  // Alignment check and lane byte-enable mask for the head access size.
  always_comb begin
    w_misalign = 1'b0;
    w_be_mask  = BE_W'(1);
    case (lsu_size_i)
      2'd0: begin
        w_misalign = 1'b0;
        w_be_mask  = BE_W'(1);
      end
      2'd1: begin
        w_misalign = lsu_eff_addr_i[0];
        w_be_mask  = BE_W'(2'b11);
      end
      2'd2: begin
        w_misalign = |lsu_eff_addr_i[1:0];
        w_be_mask  = BE_W'(4'hF);
      end
      default: begin
        // Dword only exists on a 64-bit bus; otherwise it is dropped as misaligned.
        w_misalign = (DATA_W != 64) | (|lsu_eff_addr_i[2:0]);
        w_be_mask  = BE_W'(8'hFF);
      end
    endcase
  end

  // Request FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Request FSM next state: hold in REQ until granted, chain back-to-back issues.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_REQ;
      S_REQ:   if (dmem.gnt & ~w_issue) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the popped access into the request registers; flush marks the held load killed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_req_load <= 1'b0;
      r_req_tag  <= NO_VAL;
      r_req_size <= '0;
      r_req_sgn  <= 1'b0;
      r_req_off  <= '0;
      r_req_kill <= 1'b0;
    end else if (w_issue) begin
      r_we       <= ~lsu_load_i;
      r_be       <= w_be_mask << w_off;
      r_addr     <= {lsu_eff_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
      r_wdata    <= lsu_st_data_i << {w_off, 3'b000};
      r_req_load <= lsu_load_i;
      r_req_tag  <= lsu_ld_tag_i;
      r_req_size <= lsu_size_i;
      r_req_sgn  <= lsu_signed_i;
      r_req_off  <= w_off;
      r_req_kill <= 1'b0;
    end else if (flush_i) begin
      r_req_kill <= 1'b1;
    end
  end

  // Credit counter: requests held or granted but not yet responded.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_issue, w_rsp})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Pending FIFO of granted requests, in response order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
      for (int i = 0; i < int'(MAX_OUT); i++) r_fifo[i] <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < int'(MAX_OUT); i++) r_fifo[i].kill <= 1'b1;
      end
      if (w_push) begin
        r_fifo[r_wptr] <= '{is_load: r_req_load, tag: r_req_tag, size: r_req_size,
                            sgn: r_req_sgn, off: r_req_off, kill: r_req_kill | flush_i};
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_rsp) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_rsp})
        2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign w_head     = r_fifo[r_rptr];
  assign w_lane     = dmem.rdata >> {w_head.off, 3'b000};
  assign w_rsp_kill = w_head.kill | flush_i;

  // Extract the addressed lane and sign/zero-extend it to 32 bits.
  always_comb begin
    w_ld_val = w_lane[31:0];
    case (w_head.size)
      2'd0:    w_ld_val = {{24{w_head.sgn & w_lane[7]}}, w_lane[7:0]};
      2'd1:    w_ld_val = {{16{w_head.sgn & w_lane[15]}}, w_lane[15:0]};
      default: w_ld_val = w_lane[31:0];
    endcase
  end

  // CDB broadcast one cycle after a live load response; idle otherwise.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cdb.tag <= NO_VAL;
      r_cdb.val <= '0;
    end else if (w_rsp & w_head.is_load & ~w_rsp_kill) begin
      r_cdb.tag <= w_head.tag;
      r_cdb.val <= w_ld_val;
    end else begin
      r_cdb.tag <= NO_VAL;
      r_cdb.val <= '0;
    end
  end

  // One-cycle pulse for a popped, non-squashed misaligned access.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_misalign <= 1'b0;
    else         r_misalign <= w_pop & ~w_squash & w_misalign;
  end

  assign lsu_read_o  = w_pop;
  assign cdb_load_o  = r_cdb;
  assign misalign_o  = r_misalign;
  assign dmem.req    = (r_state == S_REQ);
  assign dmem.we     = r_we;
  assign dmem.be     = r_be;
  assign dmem.addr   = r_addr;
  assign dmem.wdata  = r_wdata;

endmodule
